// File: rtl/wtc_7seg_counter_ctrl_pkg.sv
// Shared types and helpers for the button-driven two-digit BCD counter.
// Mode encodings match what the wtc_7seg digit drivers expect.
package wtc_7seg_counter_ctrl_pkg;

  localparam int MODE_W  = 3;
  localparam int DIGIT_W = 4;
  localparam int NUM_BTN = 4;

  localparam int BTN_INC   = 0;
  localparam int BTN_DEC   = 1;
  localparam int BTN_MODE  = 2;
  localparam int BTN_CLEAR = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_STATIC     = 3'd0,
    MODE_BLINK_SLOW = 3'd1,
    MODE_BLINK_MED  = 3'd2,
    MODE_BLINK_FAST = 3'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HELD,
    ST_REPEAT
  } step_state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
  } bcd_t;

  // One BCD step with wrap 99->00 / 00->99; carry/borrow lands in the same step.
  function automatic bcd_t bcd_step(input bcd_t v, input logic up);
    bcd_t r;
    r = v;
    if (up) begin
      if (v.ones == 4'd9) begin
        r.ones = 4'd0;
        r.tens = (v.tens == 4'd9) ? 4'd0 : v.tens + 4'd1;
      end else begin
        r.ones = v.ones + 4'd1;
      end
    end else begin
      if (v.ones == 4'd0) begin
        r.ones = 4'd9;
        r.tens = (v.tens == 4'd0) ? 4'd9 : v.tens - 4'd1;
      end else begin
        r.ones = v.ones - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/wtc_7seg_counter_ctrl_debounce.sv
// Single-button debouncer: the level follows the raw input only after it
// has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module wtc_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Raw,
  output logic o_Level
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cnt     <= '0;
      o_Level <= 1'b0;
    end else if (i_Raw == o_Level) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      o_Level <= i_Raw;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/wtc_7seg_counter_ctrl.sv
// Two-digit BCD counter driven by four debounced buttons: inc/dec with
// hold-to-repeat, mode cycling and clear; outputs feed two 7-seg drivers.
module wtc_7seg_counter_ctrl
  import wtc_7seg_counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 12500000,
  parameter int REPEAT_CYCLES   = 2500000,
  parameter int MODE_MAX        = 3
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Switch_1,
  input  logic               i_Switch_2,
  input  logic               i_Switch_3,
  input  logic               i_Switch_4,
  output logic [DIGIT_W-1:0] o_Ones_Num,
  output logic [DIGIT_W-1:0] o_Tens_Num,
  output logic [MODE_W-1:0]  o_Mode,
  output logic               o_Update
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [NUM_BTN-1:0] raw, level, level_q, press;

  assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    wtc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_Raw  (raw[g]),
      .o_Level(level[g])
    );
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) level_q <= '0;
    else       level_q <= level;
  end

  assign press = level & ~level_q;

  step_state_e         state;
  logic                dir_up;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [REP_W-1:0]    rep_cnt;
  bcd_t                count;
  logic [MODE_W-1:0]   mode;
  logic                update;

  logic inc_p, dec_p, clr_p, mode_p, active_level, do_step, step_up;

  assign inc_p        = press[BTN_INC];
  assign dec_p        = press[BTN_DEC];
  assign clr_p        = press[BTN_CLEAR];
  assign mode_p       = press[BTN_MODE];
  assign active_level = dir_up ? level[BTN_INC] : level[BTN_DEC];

  // Simultaneous inc+dec presses cancel; release takes priority over a due step.
  always_comb begin
    do_step = 1'b0;
    step_up = dir_up;
    case (state)
      ST_IDLE: begin
        if (inc_p ^ dec_p) begin
          do_step = 1'b1;
          step_up = inc_p;
        end
      end
      ST_HELD:   do_step = active_level && (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
      ST_REPEAT: do_step = active_level && (rep_cnt == REP_W'(REPEAT_CYCLES - 1));
      default:   do_step = 1'b0;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state    <= ST_IDLE;
      dir_up   <= 1'b1;
      hold_cnt <= '0;
      rep_cnt  <= '0;
      count    <= '0;
      mode     <= MODE_STATIC;
      update   <= 1'b0;
    end else begin
      update <= do_step | clr_p | mode_p;

      if (mode_p)
        mode <= (mode == MODE_W'(MODE_MAX)) ? MODE_STATIC : mode + 1'b1;

      if (clr_p) begin
        count    <= '0;
        state    <= ST_IDLE;
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else begin
        if (do_step)
          count <= bcd_step(count, step_up);
        case (state)
          ST_IDLE: begin
            if (inc_p ^ dec_p) begin
              state    <= ST_HELD;
              dir_up   <= inc_p;
              hold_cnt <= '0;
            end
          end
          ST_HELD: begin
            if (!active_level) begin
              state <= ST_IDLE;
            end else if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
              state   <= ST_REPEAT;
              rep_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (!active_level)
              state <= ST_IDLE;
            else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1))
              rep_cnt <= '0;
            else
              rep_cnt <= rep_cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_Ones_Num = count.ones;
  assign o_Tens_Num = count.tens;
  assign o_Mode     = mode;
  assign o_Update   = update;

endmodule

// File: tb/tb_wtc_7seg_counter_ctrl.sv
// Directed bench for the button-driven BCD counter with shortened timing
// (debounce 4, hold 20, repeat 8).
module tb_wtc_7seg_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] ones, tens;
  logic [2:0] mode;
  logic       update;
  logic       upd_seen;

  int checks = 0;
  int errors = 0;

  wtc_7seg_counter_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .MODE_MAX       (3)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst),
    .i_Switch_1(sw[0]),
    .i_Switch_2(sw[1]),
    .i_Switch_3(sw[2]),
    .i_Switch_4(sw[3]),
    .o_Ones_Num(ones),
    .o_Tens_Num(tens),
    .o_Mode    (mode),
    .o_Update  (update)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Short press: one step 5 cycles in, released well before hold expires.
  task automatic tap(input int b);
    sw[b] = 1'b1;
    tick(8);
    sw[b] = 1'b0;
    tick(8);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    sw  = 4'b0;
    tick(2);
    chk("reset_count",  {tens, ones}, 8'h00);
    chk("reset_mode",   {5'b0, mode}, 8'h00);
    chk("reset_update", {7'b0, update}, 8'h00);
    rst = 1'b0;
    tick(2);

    // clean press: step lands 5 cycles after the raw edge
    sw[0] = 1'b1;
    tick(4);
    chk("clean_pre_step", {tens, ones}, 8'h00);
    tick(1);
    chk("clean_step", {tens, ones}, 8'h01);
    chk("clean_update_hi", {7'b0, update}, 8'h01);
    tick(1);
    chk("clean_update_lo", {7'b0, update}, 8'h00);
    tick(4);
    sw[0] = 1'b0;
    tick(10);
    chk("clean_single", {tens, ones}, 8'h01);

    // bounce shorter than the debounce window, then stable
    sw[0] = 1'b1; tick(2);
    sw[0] = 1'b0; tick(2);
    sw[0] = 1'b1; tick(2);
    sw[0] = 1'b0; tick(2);
    sw[0] = 1'b1; tick(10);
    sw[0] = 1'b0; tick(10);
    chk("bounce_one_step", {tens, ones}, 8'h02);

    // mode cycling
    tap(2); chk("mode_1", {5'b0, mode}, 8'h01);
    tap(2); chk("mode_2", {5'b0, mode}, 8'h02);
    tap(2); chk("mode_3", {5'b0, mode}, 8'h03);
    tap(2); chk("mode_wrap0", {5'b0, mode}, 8'h00);
    tap(2); chk("mode_1_again", {5'b0, mode}, 8'h01);

    tap(3);
    chk("clear_count", {tens, ones}, 8'h00);
    chk("clear_keeps_mode", {5'b0, mode}, 8'h01);

    // clear at 00 still pulses update
    sw[3] = 1'b1;
    tick(5);
    chk("clear_zero_update", {7'b0, update}, 8'h01);
    chk("clear_zero_count", {tens, ones}, 8'h00);
    tick(3);
    sw[3] = 1'b0;
    tick(8);

    tap(1); chk("dec_wrap_99", {tens, ones}, 8'h99);
    tap(0); chk("inc_wrap_00", {tens, ones}, 8'h00);
    repeat (9) tap(0);
    chk("inc_to_09", {tens, ones}, 8'h09);
    tap(0); chk("carry_10", {tens, ones}, 8'h10);
    tap(1); chk("borrow_09", {tens, ones}, 8'h09);
    tap(3); chk("clear_09", {tens, ones}, 8'h00);

    // inc and dec land together: cancel
    upd_seen = 1'b0;
    sw[0] = 1'b1;
    sw[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      upd_seen = upd_seen | update;
    end
    chk("both_no_update", {7'b0, upd_seen}, 8'h00);
    chk("both_no_change", {tens, ones}, 8'h00);
    sw = 4'b0;
    tick(10);

    // auto-repeat: steps at 5, 25, 33, 41, 49, 57 cycles after raw edge
    sw[0] = 1'b1;
    tick(24);
    chk("hold_before_repeat", {tens, ones}, 8'h01);
    tick(1);
    chk("hold_first_repeat", {tens, ones}, 8'h02);
    tick(8);
    chk("repeat_step3", {tens, ones}, 8'h03);
    tick(24);
    chk("repeat_step6", {tens, ones}, 8'h06);
    tick(1);
    sw[0] = 1'b0;
    tick(20);
    chk("release_no_more", {tens, ones}, 8'h06);
    tap(3);
    chk("clear_after_repeat", {tens, ones}, 8'h00);

    // clear while repeating forces IDLE; held inc must not step again
    sw[0] = 1'b1;
    tick(33);
    chk("pre_clear_repeat", {tens, ones}, 8'h03);
    sw[3] = 1'b1;
    tick(5);
    chk("clear_in_repeat", {tens, ones}, 8'h00);
    tick(22);
    chk("idle_after_clear", {tens, ones}, 8'h00);
    sw = 4'b0;
    tick(12);
    chk("mode_untouched", {5'b0, mode}, 8'h01);

    // async reset mid-repeat, button still held afterwards
    sw[0] = 1'b1;
    tick(30);
    chk("pre_reset_count", {tens, ones}, 8'h02);
    rst = 1'b1;
    #1;
    chk("async_reset_count", {tens, ones}, 8'h00);
    chk("async_reset_mode", {5'b0, mode}, 8'h00);
    chk("async_reset_update", {7'b0, update}, 8'h00);
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("no_stale_step", {tens, ones}, 8'h00);
    tick(1);
    chk("repress_after_reset", {tens, ones}, 8'h01);
    sw[0] = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
